// File: rtl/sb_cfg_pkg.sv
// Shared definitions for the switch-block configuration chain: load-state
// encoding and the select-width / config-length helpers.
package sb_cfg_pkg;

  typedef enum logic [1:0] {
    StEmpty    = 2'd0,
    StShifting = 2'd1,
    StLoaded   = 2'd2
  } load_state_e;

  function automatic int unsigned sel_width(input int unsigned mux_size);
    return (mux_size < 2) ? 1 : $clog2(mux_size);
  endfunction

  function automatic int unsigned cfg_bits(input int unsigned chan_width,
                                           input int unsigned mux_size);
    return 2 * chan_width * sel_width(mux_size);
  endfunction

endpackage

// File: rtl/sb_cfg_chain.sv
// Serial configuration chain: shadow shift register, saturating shift counter,
// load FSM and the active register that the routing muxes decode.
module sb_cfg_chain
  import sb_cfg_pkg::*;
#(
  parameter int unsigned CFG_BITS = 20
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                ccff_head,
  input  logic                ccff_en,
  input  logic                ccff_commit,
  output logic [CFG_BITS-1:0] active,
  output logic                ccff_tail,
  output logic                cfg_loaded,
  output logic                cfg_active,
  output logic                cfg_err
);

  localparam int unsigned CNT_W = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  logic [CFG_BITS-1:0] shadow_q, active_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  load_state_e         state_q, state_d;
  logic                act_q, err_q;
  logic                commit_ok, commit_bad;

  // A commit raised together with a shift is ignored without flagging an error.
  assign commit_ok  = ccff_commit && !ccff_en && (state_q == StLoaded);
  assign commit_bad = ccff_commit && !ccff_en && (state_q != StLoaded);

  always_comb begin
    cnt_d = cnt_q;
    if (ccff_en) begin
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (commit_ok) begin
      cnt_d = '0;
    end
    if (cnt_d == '0)           state_d = StEmpty;
    else if (cnt_d == CNT_FULL) state_d = StLoaded;
    else                        state_d = StShifting;
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      state_q  <= StEmpty;
      act_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (ccff_en) shadow_q <= {shadow_q[CFG_BITS-2:0], ccff_head};
      if (commit_ok) begin
        active_q <= shadow_q;
        act_q    <= 1'b1;
        err_q    <= 1'b0;
      end else if (commit_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign active     = active_q;
  assign ccff_tail  = shadow_q[CFG_BITS-1];
  assign cfg_loaded = (state_q == StLoaded);
  assign cfg_active = act_q;
  assign cfg_err    = err_q;

endmodule

// File: rtl/sb_param_cfg.sv
// Parameterised switch block: a configuration chain plus per-track routing
// muxes that are purely combinational from data inputs to outputs.
module sb_param_cfg
  import sb_cfg_pkg::*;
#(
  parameter int unsigned CHAN_WIDTH  = 5,
  parameter int unsigned MUX_SIZE    = 3,
  parameter int unsigned N_PIN_TOP   = 10,
  parameter int unsigned N_PIN_RIGHT = 10
) (
  input  logic                   prog_clk,
  input  logic                   pReset_n,
  input  logic                   ccff_head,
  input  logic                   ccff_en,
  input  logic                   ccff_commit,
  input  logic [CHAN_WIDTH-1:0]  chany_top_in,
  input  logic [CHAN_WIDTH-1:0]  chanx_right_in,
  input  logic [N_PIN_TOP-1:0]   top_pin_in,
  input  logic [N_PIN_RIGHT-1:0] right_pin_in,
  output logic [CHAN_WIDTH-1:0]  chany_top_out,
  output logic [CHAN_WIDTH-1:0]  chanx_right_out,
  output logic                   ccff_tail,
  output logic                   cfg_loaded,
  output logic                   cfg_active,
  output logic                   cfg_err
);

  localparam int unsigned SEL_W    = sel_width(MUX_SIZE);
  localparam int unsigned CFG_BITS = cfg_bits(CHAN_WIDTH, MUX_SIZE);

  logic [CFG_BITS-1:0] active;

  sb_cfg_chain #(
    .CFG_BITS (CFG_BITS)
  ) u_chain (
    .prog_clk    (prog_clk),
    .pReset_n    (pReset_n),
    .ccff_head   (ccff_head),
    .ccff_en     (ccff_en),
    .ccff_commit (ccff_commit),
    .active      (active),
    .ccff_tail   (ccff_tail),
    .cfg_loaded  (cfg_loaded),
    .cfg_active  (cfg_active),
    .cfg_err     (cfg_err)
  );

  for (genvar i = 0; i < CHAN_WIDTH; i++) begin : g_top
    logic [SEL_W-1:0]    sel;
    logic [MUX_SIZE-1:0] cand;
    assign sel = active[i*SEL_W +: SEL_W];
    for (genvar k = 0; k < MUX_SIZE - 1; k++) begin : g_pin
      localparam int unsigned IDX = (i + k * CHAN_WIDTH) % N_PIN_TOP;
      assign cand[k] = top_pin_in[IDX];
    end
    localparam int unsigned XIDX = (i + 1) % CHAN_WIDTH;
    assign cand[MUX_SIZE-1] = chanx_right_in[XIDX];
    // Select codes past the last mux input decode to 0.
    assign chany_top_out[i] = cfg_active && ({1'b0, sel} < (SEL_W + 1)'(MUX_SIZE)) ?
                              cand[sel] : 1'b0;
  end

  for (genvar i = 0; i < CHAN_WIDTH; i++) begin : g_right
    logic [SEL_W-1:0]    sel;
    logic [MUX_SIZE-1:0] cand;
    assign sel = active[(CHAN_WIDTH + i)*SEL_W +: SEL_W];
    localparam int unsigned YIDX = (i + CHAN_WIDTH - 1) % CHAN_WIDTH;
    assign cand[0] = chany_top_in[YIDX];
    for (genvar k = 1; k < MUX_SIZE; k++) begin : g_pin
      localparam int unsigned IDX = (i + (k - 1) * CHAN_WIDTH) % N_PIN_RIGHT;
      assign cand[k] = right_pin_in[IDX];
    end
    assign chanx_right_out[i] = cfg_active && ({1'b0, sel} < (SEL_W + 1)'(MUX_SIZE)) ?
                                cand[sel] : 1'b0;
  end

endmodule

// File: tb/tb_sb_param_cfg.sv
// Bench for sb_param_cfg: directed vectors, a behavioural model checked every
// cycle, and hand-computed literal expectations at key points.
module tb_sb_param_cfg;

  localparam int W = 5, MS = 3, SW = 2, CB = 20, NPT = 10, NPR = 10;

  logic prog_clk = 1'b0;
  logic pReset_n, ccff_head, ccff_en, ccff_commit;
  logic [W-1:0]   chany_top_in, chanx_right_in, chany_top_out, chanx_right_out;
  logic [NPT-1:0] top_pin_in;
  logic [NPR-1:0] right_pin_in;
  logic ccff_tail, cfg_loaded, cfg_active, cfg_err;

  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;

  logic [CB-1:0] m_shadow = '0, m_active = '0;
  int m_cnt = 0;
  bit m_act = 1'b0, m_err = 1'b0;

  logic [CB-1:0] w1, w2, w4;

  sb_param_cfg dut (
    .prog_clk        (prog_clk),
    .pReset_n        (pReset_n),
    .ccff_head       (ccff_head),
    .ccff_en         (ccff_en),
    .ccff_commit     (ccff_commit),
    .chany_top_in    (chany_top_in),
    .chanx_right_in  (chanx_right_in),
    .top_pin_in      (top_pin_in),
    .right_pin_in    (right_pin_in),
    .chany_top_out   (chany_top_out),
    .chanx_right_out (chanx_right_out),
    .ccff_tail       (ccff_tail),
    .cfg_loaded      (cfg_loaded),
    .cfg_active      (cfg_active),
    .cfg_err         (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  // Model of the configuration behaviour.
  always @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      m_shadow <= '0; m_active <= '0; m_cnt <= 0; m_act <= 1'b0; m_err <= 1'b0;
    end else if (ccff_en) begin
      m_shadow <= {m_shadow[CB-2:0], ccff_head};
      m_cnt    <= (m_cnt < CB) ? m_cnt + 1 : CB;
    end else if (ccff_commit) begin
      if (m_cnt == CB) begin
        m_active <= m_shadow; m_cnt <= 0; m_act <= 1'b1; m_err <= 1'b0;
      end else begin
        m_err <= 1'b1;
      end
    end
  end

  function automatic logic [W-1:0] exp_top();
    logic [W-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < W; i++) begin
      s = int'((m_active >> (SW * i)) & 20'd3);
      if (!m_act)         r[i] = 1'b0;
      else if (s < MS-1)  r[i] = top_pin_in[(i + s * W) % NPT];
      else if (s == MS-1) r[i] = chanx_right_in[(i + 1) % W];
      else                r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] exp_right();
    logic [W-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < W; i++) begin
      s = int'((m_active >> (SW * (W + i))) & 20'd3);
      if (!m_act)      r[i] = 1'b0;
      else if (s == 0) r[i] = chany_top_in[(i + W - 1) % W];
      else if (s < MS) r[i] = right_pin_in[(i + (s - 1) * W) % NPR];
      else             r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check1("m_top_out",   32'(chany_top_out),   32'(exp_top()));
    check1("m_right_out", 32'(chanx_right_out), 32'(exp_right()));
    check1("m_tail",      32'(ccff_tail),       32'(m_shadow[CB-1]));
    check1("m_loaded",    32'(cfg_loaded),      32'(m_cnt == CB));
    check1("m_active",    32'(cfg_active),      32'(m_act));
    check1("m_err",       32'(cfg_err),         32'(m_err));
  endtask

  always @(negedge prog_clk) if (chk_en) check_all();

  task automatic tick();
    @(posedge prog_clk);
    #2;
  endtask

  task automatic shift_bits(input logic [CB-1:0] w, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) begin
      ccff_head = w[k];
      ccff_en   = 1'b1;
      tick();
    end
    ccff_en = 1'b0;
  endtask

  task automatic commit();
    ccff_commit = 1'b1;
    tick();
    ccff_commit = 1'b0;
  endtask

  initial begin
    w1 = 20'h93C96;  // field0=2'b10, field1=2'b01
    w2 = 20'h5A3C1;
    w4 = 20'h4C1E4;  // right track 2 field=2'b11, field0=2'b00
    pReset_n = 1'b1; ccff_head = 1'b0; ccff_en = 1'b0; ccff_commit = 1'b0;
    chany_top_in = '0; chanx_right_in = '0; top_pin_in = '0; right_pin_in = '0;
    #1 pReset_n = 1'b0;
    #3;
    check1("rst_top_out", 32'(chany_top_out), 32'h0);
    check1("rst_right_out", 32'(chanx_right_out), 32'h0);
    check1("rst_tail", 32'(ccff_tail), 32'h0);
    check1("rst_flags", 32'({cfg_loaded, cfg_active, cfg_err}), 32'h0);
    tick(); tick();
    pReset_n = 1'b1;
    chk_en = 1'b1;

    // Routing through chanx_right_in[1] with zero latency.
    shift_bits(w1, CB-1, 0);
    check1("loaded_after_20", 32'(cfg_loaded), 32'h1);
    commit();
    check1("active_after_commit", 32'(cfg_active), 32'h1);
    check1("err_after_commit", 32'(cfg_err), 32'h0);
    chanx_right_in = 5'b00000;
    #1 check1("top0_follow_lo", 32'(chany_top_out[0]), 32'h0);
    chanx_right_in = 5'b00010;
    #1 check1("top0_follow_hi", 32'(chany_top_out[0]), 32'h1);
    top_pin_in = 10'b0001000000;
    #1 check1("top1_pin6", 32'(chany_top_out[1]), 32'h1);
    tick();

    // Readback of the committed word while a new one shifts in.
    for (int k = 0; k < CB; k++) begin
      ccff_head = w2[CB-1-k];
      ccff_en   = 1'b1;
      check1("readback", 32'(ccff_tail), 32'(w1[CB-1-k]));
      tick();
    end
    ccff_en = 1'b0;
    check1("active_kept_top0", 32'(chany_top_out[0]), 32'h1);
    check1("active_kept_top1", 32'(chany_top_out[1]), 32'h1);

    // Commit together with shift at full count: shift wins, no error.
    ccff_head = 1'b1; ccff_en = 1'b1; ccff_commit = 1'b1;
    tick();
    ccff_en = 1'b0; ccff_commit = 1'b0;
    check1("en_commit_err", 32'(cfg_err), 32'h0);
    check1("en_commit_loaded", 32'(cfg_loaded), 32'h1);
    check1("en_commit_tail", 32'(ccff_tail), 32'(w2[CB-2]));
    check1("en_commit_top0", 32'(chany_top_out[0]), 32'h1);

    // Short load is rejected, completing it clears the error.
    commit();
    shift_bits(w4, CB-1, 1);
    commit();
    check1("short_err", 32'(cfg_err), 32'h1);
    check1("short_loaded", 32'(cfg_loaded), 32'h0);
    shift_bits(w4, 0, 0);
    commit();
    check1("full_err_clr", 32'(cfg_err), 32'h0);

    // Illegal select on right track 2 holds it at 0.
    for (int p = 0; p < 6; p++) begin
      chany_top_in   = (p == 0) ? 5'h1F : 5'($urandom);
      chanx_right_in = (p == 0) ? 5'h1F : 5'($urandom);
      top_pin_in     = (p == 0) ? 10'h3FF : 10'($urandom);
      right_pin_in   = (p == 0) ? 10'h3FF : 10'($urandom);
      #1;
      check1("illegal_sel", 32'(chanx_right_out[2]), 32'h0);
      check1("top0_pin0", 32'(chany_top_out[0]), 32'(top_pin_in[0]));
      tick();
    end

    // Reset in the middle of a load.
    chany_top_in = 5'h1F; chanx_right_in = 5'h1F; top_pin_in = 10'h3FF;
    right_pin_in = 10'h3FF;
    shift_bits(20'hAAAAA, 9, 0);
    pReset_n = 1'b0;
    #1;
    check1("midrst_top_out", 32'(chany_top_out), 32'h0);
    check1("midrst_right_out", 32'(chanx_right_out), 32'h0);
    check1("midrst_tail", 32'(ccff_tail), 32'h0);
    check1("midrst_flags", 32'({cfg_loaded, cfg_active, cfg_err}), 32'h0);
    tick();
    pReset_n = 1'b1;
    tick(); tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
